// File: rtl/rv_alu_exec.sv
// rv_alu_exec: execute-stage ALU with a valid/ready handshake and a 2-entry
// skid buffer (OUT slot + SKID slot). The payload {result, zero, illegal, tag}
// is computed combinationally and captured at the accepting edge.
// Optional macro RV_ALU_OVF_EN adds a registered signed-overflow flag (ovf).
module rv_alu_exec #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             illegal,
`ifdef RV_ALU_OVF_EN
    output logic             ovf,
`endif
    output logic [TAG_W-1:0] out_tag
);

`ifdef RV_ALU_OVF_EN
    localparam int PW = XLEN + TAG_W + 3;
`else
    localparam int PW = XLEN + TAG_W + 2;
`endif

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [PW-1:0]   out_q, skid_q, new_p;
    logic [XLEN-1:0] res_c, sum_c, diff_c;
    logic            ill_c, zero_c, ovf_c;
    logic            accept, drain;
    logic            ld_out_new, ld_out_skid, ld_skid;

    // ALU datapath on the presented operands
    always_comb begin
        sum_c  = a + b;
        diff_c = a - b;
        res_c  = '0;
        ill_c  = 1'b0;
        ovf_c  = 1'b0;
        case (op)
            4'b0000: res_c = a & b;
            4'b0001: res_c = a | b;
            4'b0010: begin
                res_c = sum_c;
                ovf_c = (a[XLEN-1] == b[XLEN-1]) && (sum_c[XLEN-1] != a[XLEN-1]);
            end
            4'b0110: begin
                res_c = diff_c;
                ovf_c = (a[XLEN-1] != b[XLEN-1]) && (diff_c[XLEN-1] != a[XLEN-1]);
            end
            4'b0111: res_c = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100: res_c = ~(a | b);
            default: ill_c = 1'b1;
        endcase
        zero_c = (res_c == '0);
`ifdef RV_ALU_OVF_EN
        new_p = {ovf_c, ill_c, zero_c, tag, res_c};
`else
        new_p = {ill_c, zero_c, tag, res_c};
`endif
    end

    assign accept    = in_valid && in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign drain     = out_valid && out_ready;

    // Next-state and slot-load decisions for the OUT/SKID buffer
    always_comb begin
        state_d     = state_q;
        ld_out_new  = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        case (state_q)
            S_EMPTY: if (accept) begin
                ld_out_new = 1'b1;
                state_d    = S_ONE;
            end
            S_ONE: begin
                if (accept && !drain) begin
                    ld_skid = 1'b1;
                    state_d = S_FULL;
                end else if (accept && drain) begin
                    ld_out_new = 1'b1;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: if (drain) begin
                ld_out_skid = 1'b1;
                state_d     = S_ONE;
            end
            default: state_d = S_EMPTY;
        endcase
        in_ready_d = (state_d != S_FULL);
    end

    // State, registered in_ready and slot storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            if (ld_out_new)       out_q <= new_p;
            else if (ld_out_skid) out_q <= skid_q;
            if (ld_skid)          skid_q <= new_p;
        end
    end

    assign in_ready = in_ready_q;
    assign result   = out_q[XLEN-1:0];
    assign out_tag  = out_q[XLEN +: TAG_W];
    assign zero     = out_q[XLEN+TAG_W];
    assign illegal  = out_q[XLEN+TAG_W+1];
`ifdef RV_ALU_OVF_EN
    assign ovf      = out_q[XLEN+TAG_W+2];
`endif

endmodule
